// File: rtl/decoder_stream_if.sv
// Command and output-stream signals of decoder_stream.
// The master drives commands and out_ready; the slave returns in_ready and the decoded stream.
interface decoder_stream_if #(
    parameter int N_SEL = 3,
    parameter int OUT_W = 2 ** N_SEL
);
    logic             in_valid;
    logic             in_ready;
    logic [N_SEL-1:0] in_sel;
    logic             in_en;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_sel, in_en, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_sel, in_en, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/decoder_stream.sv
// Registered N-to-2^N decoder (one-hot, thermometer, scan, inverted); word visible the cycle after accept.
// Output holds while out_ready is low; in_ready drops during scans and while a stalled word is held.
module decoder_stream #(
    parameter int N_SEL = 3
) (
    input logic         clk,
    input logic         rst,
    decoder_stream_if.slave bus
);
    localparam int OUT_W = 2 ** N_SEL;
    localparam logic [N_SEL-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_SCAN
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [N_SEL-1:0] idx_q, idx_d;
    logic [N_SEL-1:0] idx_nxt;
    logic             accept;

    function automatic logic [OUT_W-1:0] onehot(input logic [N_SEL-1:0] s);
        return OUT_W'(1) << s;
    endfunction

    // Shifting past the top bit yields zero, so s = OUT_W-1 correctly becomes all ones.
    function automatic logic [OUT_W-1:0] thermo(input logic [N_SEL-1:0] s);
        return (onehot(s) << 1) - OUT_W'(1);
    endfunction

    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.in_ready  = ~rst & (state_q != ST_SCAN)
                         & ((state_q == ST_EMPTY) | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign idx_nxt       = idx_q + N_SEL'(1);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        idx_d   = idx_q;
        if (accept) begin
            state_d = ST_HOLD;
            last_d  = 1'b1;
            idx_d   = bus.in_sel;
            if (!bus.in_en) begin
                data_d = '0;
            end else begin
                case (bus.in_mode)
                    2'd0: data_d = onehot(bus.in_sel);
                    2'd1: data_d = thermo(bus.in_sel);
                    2'd2: begin
                        data_d = onehot(bus.in_sel);
                        if (bus.in_sel != IDX_LAST) begin
                            state_d = ST_SCAN;
                            last_d  = 1'b0;
                        end
                    end
                    default: data_d = ~onehot(bus.in_sel);
                endcase
            end
        end else if (bus.out_ready) begin
            case (state_q)
                ST_HOLD: state_d = ST_EMPTY;
                ST_SCAN: begin
                    idx_d  = idx_nxt;
                    data_d = onehot(idx_nxt);
                    if (idx_nxt == IDX_LAST) begin
                        state_d = ST_HOLD;
                        last_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream: vector table, hand-written multi-cycle sequences, and randomized traffic
// checked against a queue-of-expected-words model.
module tb_decoder_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder_stream_if #(.N_SEL(3)) b3 ();
    decoder_stream_if #(.N_SEL(4)) b4 ();

    decoder_stream #(.N_SEL(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
    decoder_stream #(.N_SEL(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic [1:0] mode;
        logic [7:0] data;
        logic       last;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } word_t;

    word_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd3(input logic v, input logic [2:0] s, input logic e, input logic [1:0] m);
        b3.in_valid = v;
        b3.in_sel   = s;
        b3.in_en    = e;
        b3.in_mode  = m;
    endtask

    task automatic expect3(input string name, input logic v, input logic [7:0] d, input logic l);
        check({name, "_valid"}, 32'(b3.out_valid), 32'(v));
        if (v) begin
            check({name, "_data"}, 32'(b3.out_data), 32'(d));
            check({name, "_last"}, 32'(b3.out_last), 32'(l));
        end
    endtask

    // Reference: each command expands into its full list of output words.
    function automatic void expand(input logic [2:0] s, input logic e, input logic [1:0] m);
        int t;
        if (!e) begin
            q.push_back('{d: 8'h00, l: 1'b1});
        end else if (m == 2'd0) begin
            q.push_back('{d: 8'(1 << s), l: 1'b1});
        end else if (m == 2'd1) begin
            t = (1 << (int'(s) + 1)) - 1;
            q.push_back('{d: 8'(t), l: 1'b1});
        end else if (m == 2'd3) begin
            q.push_back('{d: ~8'(1 << s), l: 1'b1});
        end else begin
            for (int k = int'(s); k < 8; k++)
                q.push_back('{d: 8'(1 << k), l: (k == 7)});
        end
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = '{sel: 3'd5, en: 1'b1, mode: 2'd0, data: 8'h20, last: 1'b1};
        vecs[1] = '{sel: 3'd2, en: 1'b1, mode: 2'd1, data: 8'h07, last: 1'b1};
        vecs[2] = '{sel: 3'd2, en: 1'b1, mode: 2'd3, data: 8'hFB, last: 1'b1};
        vecs[3] = '{sel: 3'd0, en: 1'b1, mode: 2'd1, data: 8'h01, last: 1'b1};
        vecs[4] = '{sel: 3'd7, en: 1'b1, mode: 2'd1, data: 8'hFF, last: 1'b1};
        vecs[5] = '{sel: 3'd1, en: 1'b0, mode: 2'd2, data: 8'h00, last: 1'b1};
        vecs[6] = '{sel: 3'd7, en: 1'b1, mode: 2'd2, data: 8'h80, last: 1'b1};
        vecs[7] = '{sel: 3'd3, en: 1'b0, mode: 2'd3, data: 8'h00, last: 1'b1};
        vecs[8] = '{sel: 3'd0, en: 1'b1, mode: 2'd3, data: 8'hFE, last: 1'b1};
        vecs[9] = '{sel: 3'd7, en: 1'b1, mode: 2'd0, data: 8'h80, last: 1'b1};

        rst = 1'b1;
        cmd3(1'b0, 3'd0, 1'b0, 2'd0);
        b3.out_ready = 1'b0;
        b4.in_valid  = 1'b0;
        b4.in_sel    = 4'd0;
        b4.in_en     = 1'b0;
        b4.in_mode   = 2'd0;
        b4.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(b3.out_valid), 32'd0);
        check("rst_data", 32'(b3.out_data), 32'd0);
        check("rst_last", 32'(b3.out_last), 32'd0);
        check("rst_in_ready", 32'(b3.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(b3.in_ready), 32'd1);
        tick();

        // Single-word vectors issued back to back: each cycle must accept and show the previous word.
        b3.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cmd3(1'b1, vecs[i].sel, vecs[i].en, vecs[i].mode);
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(b3.in_ready), 32'd1);
            if (i > 0)
                expect3($sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].data, vecs[i-1].last);
            tick();
        end
        cmd3(1'b0, 3'd0, 1'b0, 2'd0);
        #1;
        expect3("vec9", 1'b1, vecs[9].data, vecs[9].last);
        tick();
        expect3("vec_drain", 1'b0, 8'h00, 1'b0);

        // Scan sel=5 with a follow-up command waiting upstream.
        cmd3(1'b1, 3'd5, 1'b1, 2'd2);
        tick();
        cmd3(1'b1, 3'd0, 1'b1, 2'd0);
        #1;
        expect3("scan5_w0", 1'b1, 8'h20, 1'b0);
        check("scan5_w0_in_ready", 32'(b3.in_ready), 32'd0);
        tick();
        expect3("scan5_w1", 1'b1, 8'h40, 1'b0);
        check("scan5_w1_in_ready", 32'(b3.in_ready), 32'd0);
        tick();
        expect3("scan5_w2", 1'b1, 8'h80, 1'b1);
        check("scan5_w2_in_ready", 32'(b3.in_ready), 32'd1);
        tick();
        cmd3(1'b0, 3'd0, 1'b0, 2'd0);
        #1;
        expect3("scan5_next", 1'b1, 8'h01, 1'b1);
        tick();
        expect3("scan5_drain", 1'b0, 8'h00, 1'b0);

        // Backpressure on scan sel=6.
        b3.out_ready = 1'b0;
        cmd3(1'b1, 3'd6, 1'b1, 2'd2);
        tick();
        cmd3(1'b0, 3'd0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            expect3($sformatf("bp_stall%0d", i), 1'b1, 8'h40, 1'b0);
            check($sformatf("bp_stall%0d_in_ready", i), 32'(b3.in_ready), 32'd0);
            tick();
        end
        b3.out_ready = 1'b1;
        #1;
        expect3("bp_w0", 1'b1, 8'h40, 1'b0);
        tick();
        expect3("bp_w1", 1'b1, 8'h80, 1'b1);
        tick();
        expect3("bp_drain", 1'b0, 8'h00, 1'b0);

        // Reset during the second word of a scan.
        cmd3(1'b1, 3'd4, 1'b1, 2'd2);
        tick();
        cmd3(1'b0, 3'd0, 1'b0, 2'd0);
        #1;
        expect3("rscan_w0", 1'b1, 8'h10, 1'b0);
        tick();
        expect3("rscan_w1", 1'b1, 8'h20, 1'b0);
        rst = 1'b1;
        #1;
        check("rscan_rst_in_ready", 32'(b3.in_ready), 32'd0);
        tick();
        check("rscan_valid", 32'(b3.out_valid), 32'd0);
        check("rscan_data", 32'(b3.out_data), 32'd0);
        rst = 1'b0;
        #1;
        check("rscan_in_ready", 32'(b3.in_ready), 32'd1);
        tick();
        check("rscan_quiet", 32'(b3.out_valid), 32'd0);

        // Wider instance.
        b4.out_ready = 1'b1;
        b4.in_valid  = 1'b1;
        b4.in_sel    = 4'd15;
        b4.in_en     = 1'b1;
        b4.in_mode   = 2'd0;
        tick();
        b4.in_valid = 1'b0;
        #1;
        check("n4_oh_data", 32'(b4.out_data), 32'h8000);
        check("n4_oh_last", 32'(b4.out_last), 32'd1);
        tick();
        b4.in_valid = 1'b1;
        b4.in_sel   = 4'd14;
        b4.in_mode  = 2'd2;
        tick();
        b4.in_valid = 1'b0;
        #1;
        check("n4_scan_w0_data", 32'(b4.out_data), 32'h4000);
        check("n4_scan_w0_last", 32'(b4.out_last), 32'd0);
        tick();
        check("n4_scan_w1_data", 32'(b4.out_data), 32'h8000);
        check("n4_scan_w1_last", 32'(b4.out_last), 32'd1);
        tick();
        check("n4_scan_drain", 32'(b4.out_valid), 32'd0);

        // Randomized traffic against the expected-word queue.
        q.delete();
        begin
            logic held;
            logic exp_rdy, exp_vld, fire_in, fire_out;
            held = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (!held)
                    cmd3($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)),
                         $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)));
                b3.out_ready = ($urandom_range(0, 3) != 0);
                rst = ($urandom_range(0, 199) == 0);
                #1;
                exp_vld = (q.size() != 0);
                exp_rdy = !rst && (q.size() <= 1) && (q.size() == 0 || b3.out_ready);
                check("rnd_valid", 32'(b3.out_valid), 32'(exp_vld));
                check("rnd_in_ready", 32'(b3.in_ready), 32'(exp_rdy));
                if (exp_vld) begin
                    check("rnd_data", 32'(b3.out_data), 32'(q[0].d));
                    check("rnd_last", 32'(b3.out_last), 32'(q[0].l));
                end
                fire_out = exp_vld && b3.out_ready;
                fire_in  = b3.in_valid && exp_rdy;
                held     = b3.in_valid && !fire_in;
                tick();
                if (rst) begin
                    q.delete();
                end else begin
                    if (fire_out) void'(q.pop_front());
                    if (fire_in) expand(b3.in_sel, b3.in_en, b3.in_mode);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
